// File: rtl/dwt_pkg.sv
// Shared constants and helpers for the Haar wavelet processing element.
package dwt_pkg;

  localparam logic MODE_HAAR = 1'b0;
  localparam logic MODE_PASS = 1'b1;

  // Tag width wide enough to address the larger image dimension.
  function automatic int ptr_w(input int width, input int height);
    return $clog2((width > height) ? width : height);
  endfunction

endpackage

// File: rtl/dwt_round_sat.sv
// Halve a DATA_W+1 sum/difference (floor, or round-half-up under HAAR_ROUND_EN)
// and saturate it into DATA_W bits, either unsigned or two's-complement.
module dwt_round_sat #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W:0]   val_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] res_o
);

  logic        [DATA_W+1:0] ext;
  logic signed [DATA_W+1:0] shifted_s;
  logic        [DATA_W+1:0] shifted_u;
  logic        [DATA_W+1:0] shifted;

  always_comb begin
    ext = {signed_i & val_i[DATA_W], val_i};
`ifdef HAAR_ROUND_EN
    ext = ext + (DATA_W + 2)'(1);
`endif
    // Keep the arithmetic shift in its own statement so it stays signed.
    shifted_s = $signed(ext) >>> 1;
    shifted_u = ext >> 1;
    shifted   = signed_i ? shifted_s : shifted_u;

    if (signed_i) begin
      if (shifted[DATA_W+1:DATA_W-1] == 3'b000 || shifted[DATA_W+1:DATA_W-1] == 3'b111)
        res_o = shifted[DATA_W-1:0];
      else if (shifted[DATA_W+1])
        res_o = {1'b1, {(DATA_W-1){1'b0}}};
      else
        res_o = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      res_o = (shifted[DATA_W+1:DATA_W] != 2'b00) ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/haar_pe.sv
// Two-stage valid/ready Haar lifting element: S1 forms sum/diff, S2 halves and
// saturates into {L, H}, or forwards the raw pair in PASS mode. Rounding: HAAR_ROUND_EN.
module haar_pe
  import dwt_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int WIDTH  = 256,
  parameter  int HEIGHT = 256,
  localparam int PTR_W  = ptr_w(WIDTH, HEIGHT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W-1:0] pixel_input,
  input  logic                i_mode,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [PTR_W-1:0]    i_row_column_pointer,
  input  logic [PTR_W-1:0]    i_pixel_pointer,
  output logic [2*DATA_W-1:0] pixel_output,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [PTR_W-1:0]    o_row_column_pointer,
  output logic [PTR_W-1:0]    o_pixel_pointer,
  output logic                o_frame_end
);

  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(HEIGHT - 1);
  localparam logic [PTR_W-1:0] LAST_PIX = PTR_W'(WIDTH / 2 - 1);

  logic                s1_valid_q, s1_valid_d;
  logic [DATA_W:0]     s1_sum_q, s1_sum_d;
  logic [DATA_W:0]     s1_diff_q, s1_diff_d;
  logic [2*DATA_W-1:0] s1_raw_q, s1_raw_d;
  logic                s1_mode_q, s1_mode_d;
  logic [PTR_W-1:0]    s1_row_q, s1_row_d;
  logic [PTR_W-1:0]    s1_pix_q, s1_pix_d;

  logic                s2_valid_q, s2_valid_d;
  logic [2*DATA_W-1:0] s2_data_q, s2_data_d;
  logic [PTR_W-1:0]    s2_row_q, s2_row_d;
  logic [PTR_W-1:0]    s2_pix_q, s2_pix_d;
  logic                s2_fe_q, s2_fe_d;

  logic                s2_take;
  logic [DATA_W-1:0]   l_res, h_res;

  // An empty S2 always takes from S1, so bubbles never stall the source.
  assign s2_take = !s2_valid_q || o_ready;
  assign i_ready = !s1_valid_q || s2_take;

  dwt_round_sat #(.DATA_W(DATA_W)) u_low (
    .val_i    (s1_sum_q),
    .signed_i (1'b0),
    .res_o    (l_res)
  );

  dwt_round_sat #(.DATA_W(DATA_W)) u_high (
    .val_i    (s1_diff_q),
    .signed_i (1'b1),
    .res_o    (h_res)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_diff_d  = s1_diff_q;
    s1_raw_d   = s1_raw_q;
    s1_mode_d  = s1_mode_q;
    s1_row_d   = s1_row_q;
    s1_pix_d   = s1_pix_q;
    if (i_ready) s1_valid_d = i_valid;
    if (i_valid && i_ready) begin
      s1_sum_d  = {1'b0, pixel_input[2*DATA_W-1:DATA_W]} + {1'b0, pixel_input[DATA_W-1:0]};
      s1_diff_d = {1'b0, pixel_input[2*DATA_W-1:DATA_W]} - {1'b0, pixel_input[DATA_W-1:0]};
      s1_raw_d  = pixel_input;
      s1_mode_d = i_mode;
      s1_row_d  = i_row_column_pointer;
      s1_pix_d  = i_pixel_pointer;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_row_d   = s2_row_q;
    s2_pix_d   = s2_pix_q;
    s2_fe_d    = s2_fe_q;
    if (s2_take) s2_valid_d = s1_valid_q;
    if (s2_take && s1_valid_q) begin
      s2_data_d = (s1_mode_q == MODE_PASS) ? s1_raw_q : {l_res, h_res};
      s2_row_d  = s1_row_q;
      s2_pix_d  = s1_pix_q;
      s2_fe_d   = (s1_row_q == LAST_ROW) && (s1_pix_q == LAST_PIX);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_diff_q  <= '0;
      s1_raw_q   <= '0;
      s1_mode_q  <= MODE_HAAR;
      s1_row_q   <= '0;
      s1_pix_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_row_q   <= '0;
      s2_pix_q   <= '0;
      s2_fe_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_diff_q  <= s1_diff_d;
      s1_raw_q   <= s1_raw_d;
      s1_mode_q  <= s1_mode_d;
      s1_row_q   <= s1_row_d;
      s1_pix_q   <= s1_pix_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_row_q   <= s2_row_d;
      s2_pix_q   <= s2_pix_d;
      s2_fe_q    <= s2_fe_d;
    end
  end

  assign o_valid              = s2_valid_q;
  assign pixel_output         = s2_data_q;
  assign o_row_column_pointer = s2_row_q;
  assign o_pixel_pointer      = s2_pix_q;
  assign o_frame_end          = s2_fe_q;

endmodule

// File: tb/tb_haar_pe.sv
// Directed bench for haar_pe (DATA_W=8, 256x256); expectations follow HAAR_ROUND_EN.
module tb_haar_pe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pixel_input;
  logic        i_mode;
  logic        i_valid;
  logic        i_ready;
  logic [7:0]  i_row_column_pointer;
  logic [7:0]  i_pixel_pointer;
  logic [15:0] pixel_output;
  logic        o_valid;
  logic        o_ready;
  logic [7:0]  o_row_column_pointer;
  logic [7:0]  o_pixel_pointer;
  logic        o_frame_end;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] bp_in  [4];
  logic        bp_mode[4];
  logic [15:0] bp_exp [4];

  haar_pe #(.DATA_W(8), .WIDTH(256), .HEIGHT(256)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .pixel_input          (pixel_input),
    .i_mode               (i_mode),
    .i_valid              (i_valid),
    .i_ready              (i_ready),
    .i_row_column_pointer (i_row_column_pointer),
    .i_pixel_pointer      (i_pixel_pointer),
    .pixel_output         (pixel_output),
    .o_valid              (o_valid),
    .o_ready              (o_ready),
    .o_row_column_pointer (o_row_column_pointer),
    .o_pixel_pointer      (o_pixel_pointer),
    .o_frame_end          (o_frame_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic present(input int k);
    pixel_input          = bp_in[k];
    i_mode               = bp_mode[k];
    i_row_column_pointer = 8'd3;
    i_pixel_pointer      = k[7:0];
    i_valid              = 1'b1;
  endtask

  // One beat through an empty pipe: checks acceptance, 2-cycle latency, data, tags.
  task automatic single(input string name, input logic [15:0] pin, input logic mode,
                        input logic [7:0] row, input logic [7:0] pix,
                        input logic [15:0] exp, input logic exp_fe);
    @(negedge clk);
    pixel_input = pin; i_mode = mode; i_row_column_pointer = row; i_pixel_pointer = pix;
    i_valid = 1'b1; o_ready = 1'b1;
    #1 check({name, "_iready"}, i_ready, 1);
    @(negedge clk);
    i_valid = 1'b0;
    check({name, "_lat1"}, o_valid, 0);
    @(negedge clk);
    check({name, "_valid"}, o_valid, 1);
    check({name, "_data"}, pixel_output, exp);
    check({name, "_row"}, o_row_column_pointer, row);
    check({name, "_pix"}, o_pixel_pointer, pix);
    check({name, "_fe"}, o_frame_end, exp_fe);
    $display("beat %s in=%h out=%h tags=(%0d,%0d) fe=%0b", name, pin, pixel_output,
             o_row_column_pointer, o_pixel_pointer, o_frame_end);
  endtask

  initial begin
    logic [15:0] e_0_255, e_255_0, e_b1;
    int idx, nout;
`ifdef HAAR_ROUND_EN
    e_0_255 = 16'h8081; e_255_0 = 16'h807F; e_b1 = 16'h120D;
`else
    e_0_255 = 16'h7F80; e_255_0 = 16'h7F7F; e_b1 = 16'h110C;
`endif
    bp_in[0] = {8'd10, 8'd20};   bp_mode[0] = 1'b0; bp_exp[0] = 16'h0FFB;
    bp_in[1] = {8'd30, 8'd5};    bp_mode[1] = 1'b0; bp_exp[1] = e_b1;
    bp_in[2] = 16'h1234;         bp_mode[2] = 1'b1; bp_exp[2] = 16'h1234;
    bp_in[3] = {8'd255, 8'd255}; bp_mode[3] = 1'b0; bp_exp[3] = 16'hFF00;

    rst = 1'b1; pixel_input = '0; i_mode = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
    i_row_column_pointer = '0; i_pixel_pointer = '0;
    #2 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_ovalid", o_valid, 0);
    check("rst_data", pixel_output, 0);
    check("rst_tags", {o_row_column_pointer, o_pixel_pointer}, 0);
    check("rst_fe", o_frame_end, 0);
    rst = 1'b1;
    #1 check("rel_iready", i_ready, 1);

    single("h200_100", {8'd200, 8'd100}, 1'b0, 8'd1, 8'd2, 16'h9632, 1'b0);
    single("h100_200", {8'd100, 8'd200}, 1'b0, 8'd7, 8'd8, 16'h96CE, 1'b0);
    single("h0_255", {8'd0, 8'd255}, 1'b0, 8'd0, 8'd0, e_0_255, 1'b0);
    single("h255_0", {8'd255, 8'd0}, 1'b0, 8'd0, 8'd1, e_255_0, 1'b0);
    single("pass", 16'hABCD, 1'b1, 8'd5, 8'd9, 16'hABCD, 1'b0);
    single("fe_last", {8'd4, 8'd2}, 1'b0, 8'd255, 8'd127, 16'h0301, 1'b1);
    single("fe_pix", {8'd4, 8'd2}, 1'b0, 8'd255, 8'd126, 16'h0301, 1'b0);
    single("fe_row", 16'h5A5A, 1'b1, 8'd254, 8'd127, 16'h5A5A, 1'b0);

    // Backpressure: fill both stages with o_ready low, then drain.
    @(negedge clk); o_ready = 1'b0; present(0);
    #1 check("bp_rdy0", i_ready, 1);
    @(negedge clk); present(1);
    #1 check("bp_rdy1", i_ready, 1);
    @(negedge clk); present(2);
    #1 check("bp_full_ready", i_ready, 0);
    check("bp_full_valid", o_valid, 1);
    check("bp_hold0", pixel_output, bp_exp[0]);
    @(negedge clk);
    check("bp_hold1", pixel_output, bp_exp[0]);
    check("bp_hold1_pix", o_pixel_pointer, 0);
    check("bp_hold1_ready", i_ready, 0);
    @(negedge clk);
    check("bp_hold2", pixel_output, bp_exp[0]);
    check("bp_hold2_ready", i_ready, 0);
    idx = 2; nout = 0;
    for (int c = 0; c < 30 && nout < 4; c++) begin
      @(negedge clk);
      o_ready = 1'b1;
      if (idx < 4) present(idx); else i_valid = 1'b0;
      #1;
      if (o_valid) begin
        check("bp_out", pixel_output, bp_exp[nout]);
        check("bp_out_pix", o_pixel_pointer, nout);
        $display("beat bp%0d out=%h tags=(%0d,%0d)", nout, pixel_output,
                 o_row_column_pointer, o_pixel_pointer);
        nout++;
      end
      if (i_valid && i_ready) idx++;
    end
    check("bp_count", nout, 4);
    @(negedge clk); i_valid = 1'b0;
    @(negedge clk);
    check("bp_no_dup", o_valid, 0);

    // Reset with both stages occupied.
    @(negedge clk); o_ready = 1'b0; present(0);
    @(negedge clk); present(1);
    @(negedge clk); i_valid = 1'b0;
    #1 check("mid_full_valid", o_valid, 1);
    check("mid_full_ready", i_ready, 0);
    rst = 1'b0;
    #1 check("mid_rst_valid", o_valid, 0);
    check("mid_rst_data", pixel_output, 0);
    @(negedge clk); rst = 1'b1; o_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_no_stale", o_valid, 0);
    end
    single("post_rst", {8'd200, 8'd100}, 1'b0, 8'd2, 8'd3, 16'h9632, 1'b0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
